// File: rtl/painter_pkg.sv
// painter_pkg: geometry, widths and FSM states for sprite_painter.
//   SCREEN_W/H, SHEET_W/H : framebuffer and sprite-sheet dimensions
//   ROM_AW/FB_AW          : sheet-ROM and framebuffer address widths
//   PIXEL_W, TRANSPARENT  : pixel width and the "no write" colour
//   BG_COLOR              : fill colour of the optional clear phase
package painter_pkg;
    localparam int SCREEN_W = 1280;
    localparam int SCREEN_H = 300;
    localparam int SHEET_W  = 2404;
    localparam int SHEET_H  = 140;
    localparam int FB_WORDS = SCREEN_W * SCREEN_H;
    localparam int ROM_AW   = $clog2(SHEET_W * SHEET_H);
    localparam int FB_AW    = $clog2(FB_WORDS);
    localparam int COORD_W  = 13;
    localparam int PIXEL_W  = 2;
    localparam logic [PIXEL_W-1:0] TRANSPARENT = '0;
    localparam logic [PIXEL_W-1:0] BG_COLOR    = 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAW,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/runner_pkg.sv
// runner_pkg: shared render-slot descriptor types from the game-logic block.
//   RENDER_SLOTS : number of descriptor slots handed to the painter
//   sprite_t     : sprite-sheet rectangle (x, y, w, h); w=0 or h=0 means empty
//   pos_t        : signed screen position of the sprite's top-left corner
package runner_pkg;
    localparam int RENDER_SLOTS = 32;

    typedef struct packed {
        logic [11:0] x;
        logic [7:0]  y;
        logic [7:0]  w;
        logic [7:0]  h;
    } sprite_t;

    typedef struct packed {
        logic signed [12:0] x;
        logic signed [12:0] y;
    } pos_t;
endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: row/column walker for one latched sprite descriptor.
//   clk, rst  : clock, synchronous active-high reset
//   load      : latch spr/pos and restart at row 0, column 0
//   step      : advance one pixel in row-major order
//   spr, pos  : descriptor to latch
//   rom_addr  : sheet address of the current pixel
//   fb_addr   : framebuffer address of the current pixel (valid when on_screen)
//   on_screen : current pixel lies inside the framebuffer
//   last      : current pixel is the sprite's final pixel
module blit_addr_gen
    import painter_pkg::*;
    import runner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  sprite_t           spr,
    input  pos_t              pos,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              on_screen,
    output logic              last
);
    localparam logic signed [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);

    sprite_t                   spr_q;
    pos_t                      pos_q;
    logic [7:0]                row;
    logic [7:0]                col;
    logic signed [COORD_W-1:0] px;
    logic signed [COORD_W-1:0] py;

    always_ff @(posedge clk) begin
        if (load) begin
            spr_q <= spr;
            pos_q <= pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == spr_q.w - 8'd1) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

    assign rom_addr = (ROM_AW'(spr_q.y) + ROM_AW'(row)) * ROM_AW'(SHEET_W)
                    + ROM_AW'(spr_q.x) + ROM_AW'(col);

    assign px = pos_q.x + $signed({5'd0, col});
    assign py = pos_q.y + $signed({5'd0, row});

    // Sign bit clear means the coordinate is non-negative.
    assign on_screen = !px[COORD_W-1] && (px < SCR_W) && !py[COORD_W-1] && (py < SCR_H);

    // Only meaningful when on_screen, where both coordinates fit in 12 bits.
    assign fb_addr = FB_AW'(py[COORD_W-2:0]) * FB_AW'(SCREEN_W) + FB_AW'(px[COORD_W-2:0]);

    assign last = (col == spr_q.w - 8'd1) && (row == spr_q.h - 8'd1);
endmodule

// File: rtl/sprite_painter.sv
// sprite_painter: blits per-slot sprite descriptors into the back framebuffer,
// one pixel per cycle, slot 0 first (so it ends up at the back).
//   clk, rst          : clock, synchronous active-high reset
//   frame_start       : pulse that starts a frame (ignored while busy)
//   sprite, pos       : descriptor table, held stable by the caller while busy
//   rom_addr/rom_data : sprite-sheet ROM, data valid one cycle after address
//   fb_addr/data/we   : framebuffer write port
//   busy              : frame in progress
//   painter_finished  : frame complete, held until the next accepted frame_start
// Build option: define SPRITE_PAINTER_CLEAR_EN to fill the framebuffer with
// BG_COLOR before the sprites are drawn.
module sprite_painter
    import painter_pkg::*;
    import runner_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  sprite_t            sprite [RENDER_SLOTS],
    input  pos_t               pos [RENDER_SLOTS],
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [PIXEL_W-1:0] rom_data,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [PIXEL_W-1:0] fb_data,
    output logic               fb_we,
    output logic               busy,
    output logic               painter_finished
);
    localparam int SLOT_W = $clog2(RENDER_SLOTS + 1);
    localparam int IDX_W  = $clog2(RENDER_SLOTS);

    state_t              state, state_nx;
    logic [SLOT_W-1:0]   slot;
    logic [IDX_W-1:0]    slot_idx;
    logic                slot_empty, slot_end;
    logic                drain_cnt;
    logic                accept, load, step, slot_inc, finish;
    logic [ROM_AW-1:0]   gen_rom_addr;
    logic [FB_AW-1:0]    gen_fb_addr;
    logic                gen_on_screen, gen_last;
    logic                clr_issue, clr_last;
    logic [FB_AW-1:0]    clr_addr;
    logic                vld_p0, vld_p1, clr_p1;
    logic [FB_AW-1:0]    addr_p0, addr_p1;

    assign slot_idx   = slot[IDX_W-1:0];
    assign slot_empty = (sprite[slot_idx].w == 8'd0) || (sprite[slot_idx].h == 8'd0);
    // The slot counter runs one past the table; that extra SCAN cycle is the
    // one that hands over to DRAIN.
    assign slot_end   = (slot == SLOT_W'(RENDER_SLOTS));

`ifdef SPRITE_PAINTER_CLEAR_EN
    localparam state_t START_ST = CLEAR;
    logic [FB_AW-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != CLEAR) clr_cnt <= '0;
        else                       clr_cnt <= clr_cnt + 1'b1;
    end

    assign clr_issue = (state == CLEAR);
    assign clr_addr  = clr_cnt;
    assign clr_last  = (clr_cnt == FB_AW'(FB_WORDS - 1));
`else
    localparam state_t START_ST = SCAN;
    assign clr_issue = 1'b0;
    assign clr_addr  = '0;
    assign clr_last  = 1'b0;
`endif

    blit_addr_gen u_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .spr       (sprite[slot_idx]),
        .pos       (pos[slot_idx]),
        .rom_addr  (gen_rom_addr),
        .fb_addr   (gen_fb_addr),
        .on_screen (gen_on_screen),
        .last      (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            slot             <= '0;
            drain_cnt        <= 1'b0;
            busy             <= 1'b0;
            painter_finished <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (accept) begin
                busy             <= 1'b1;
                painter_finished <= 1'b0;
                slot             <= '0;
            end else if (slot_inc) begin
                slot <= slot + 1'b1;
            end
            if (finish) begin
                busy             <= 1'b0;
                painter_finished <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        slot_inc = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (frame_start) begin
                    accept   = 1'b1;
                    state_nx = START_ST;
                end
            end
            CLEAR: begin
                if (clr_last) state_nx = SCAN;
            end
            SCAN: begin
                if (slot_end) begin
                    state_nx = DRAIN;
                end else begin
                    load = 1'b1;
                    if (slot_empty) slot_inc = 1'b1;
                    else            state_nx = DRAW;
                end
            end
            DRAW: begin
                step = 1'b1;
                if (gen_last) begin
                    slot_inc = 1'b1;
                    state_nx = SCAN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rom_addr = (state == DRAW) ? gen_rom_addr : '0;
    assign vld_p0   = ((state == DRAW) && gen_on_screen) || clr_issue;
    assign addr_p0  = clr_issue ? clr_addr : gen_fb_addr;

    // ---- stage 1: address/valid registered alongside the ROM read ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            clr_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            clr_p1 <= clr_issue;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1 <= addr_p0;
    end

    // ---- stage 2: ROM data arrives, transparent pixels are dropped ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we   <= vld_p1 && (clr_p1 || (rom_data != TRANSPARENT));
            fb_addr <= addr_p1;
            fb_data <= clr_p1 ? BG_COLOR : rom_data;
        end
    end
endmodule

// File: tb/tb_sprite_painter.sv
// tb_sprite_painter: directed and randomized frames for sprite_painter,
// compared against a write-list model computed from the descriptor table.
`timescale 1ns/1ps
module tb_sprite_painter;
    import painter_pkg::*;
    import runner_pkg::*;

    localparam int ROM_WORDS = SHEET_W * SHEET_H;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_start;
    sprite_t            sprite [RENDER_SLOTS];
    pos_t               pos [RENDER_SLOTS];
    logic [ROM_AW-1:0]  rom_addr;
    logic [PIXEL_W-1:0] rom_data;
    logic [FB_AW-1:0]   fb_addr;
    logic [PIXEL_W-1:0] fb_data;
    logic               fb_we;
    logic               busy;
    logic               painter_finished;

    logic [PIXEL_W-1:0] rom_mem [ROM_WORDS];
    int total = 0;
    int bad   = 0;
    int got_q[$];
    int exp_q[$];
    int exp_cycles;

    always #5 clk = ~clk;

    sprite_painter dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .sprite           (sprite),
        .pos              (pos),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .fb_addr          (fb_addr),
        .fb_data          (fb_data),
        .fb_we            (fb_we),
        .busy             (busy),
        .painter_finished (painter_finished)
    );

    always @(posedge clk) begin
        if (int'(rom_addr) < ROM_WORDS) rom_data <= rom_mem[rom_addr];
        else                            rom_data <= '0;
    end

    always @(negedge clk) begin
        if (fb_we === 1'b1) got_q.push_back(int'(fb_addr) * 4 + int'(fb_data));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -1;
    endfunction

    task automatic clear_slots();
        for (int s = 0; s < RENDER_SLOTS; s++) begin
            sprite[s] = '0;
            pos[s]    = '0;
        end
    endtask

    task automatic set_slot(input int s, input int sx, input int sy, input int w,
                            input int h, input int px, input int py);
        sprite[s].x = 12'(sx);
        sprite[s].y = 8'(sy);
        sprite[s].w = 8'(w);
        sprite[s].h = 8'(h);
        pos[s].x    = 13'(px);
        pos[s].y    = 13'(py);
    endtask

    task automatic fill_rom(input int v);
        for (int a = 0; a < ROM_WORDS; a++) rom_mem[a] = 2'(v);
    endtask

    // Expected writes (addr*4+data) in order, and frame length in cycles.
    function automatic void build_model();
        exp_q.delete();
        exp_cycles = 35;
`ifdef SPRITE_PAINTER_CLEAR_EN
        for (int a = 0; a < FB_WORDS; a++) exp_q.push_back(a * 4 + int'(BG_COLOR));
        exp_cycles += FB_WORDS;
`endif
        for (int s = 0; s < RENDER_SLOTS; s++) begin
            int w, h, sx, sy, x0, y0, px, py, d;
            w  = int'(sprite[s].w);
            h  = int'(sprite[s].h);
            sx = int'(sprite[s].x);
            sy = int'(sprite[s].y);
            x0 = int'(pos[s].x);
            y0 = int'(pos[s].y);
            if (w == 0 || h == 0) continue;
            exp_cycles += w * h;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    px = x0 + c;
                    py = y0 + r;
                    if (px >= 0 && px < SCREEN_W && py >= 0 && py < SCREEN_H) begin
                        d = int'(rom_mem[(sy + r) * SHEET_W + sx + c]);
                        if (d != 0) exp_q.push_back((py * SCREEN_W + px) * 4 + d);
                    end
                end
            end
        end
    endfunction

    task automatic run_frame(input string tag, input int pulse_at);
        int  n;
        bit  done;
        int  m;
        got_q.delete();
        build_model();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        check({tag, "_busy_up"}, 64'(busy), 64'(1));
        check({tag, "_fin_low"}, 64'(painter_finished), 64'(0));
        n = 0;
        done = 0;
        while (!done && n < exp_cycles + 50) begin
            if (n == pulse_at) frame_start = 1'b1;
            @(posedge clk);
            #1 frame_start = 1'b0;
            n++;
            if (painter_finished === 1'b1) done = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_cycles));
        check({tag, "_busy_down"}, 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m && bad < 20; i++)
            check($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic reset_mid_draw();
        clear_slots();
        set_slot(18, 10, 0, 4, 2, 100, 50);
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("rst_pre_we", 64'(fb_we), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_we",       64'(fb_we), 64'(0));
        check("rst_busy",     64'(busy), 64'(0));
        check("rst_fin",      64'(painter_finished), 64'(0));
        check("rst_rom_addr", 64'(rom_addr), 64'(0));
        check("rst_fb_addr",  64'(fb_addr), 64'(0));
        check("rst_fb_data",  64'(fb_data), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("rst_idle_we",   64'(fb_we), 64'(0));
        check("rst_idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int found, last_d;
        rst = 1'b1;
        frame_start = 1'b0;
        clear_slots();
        fill_rom(1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_we",       64'(fb_we), 64'(0));
        check("reset_fb_addr",  64'(fb_addr), 64'(0));
        check("reset_fb_data",  64'(fb_data), 64'(0));
        check("reset_rom_addr", 64'(rom_addr), 64'(0));
        check("reset_busy",     64'(busy), 64'(0));
        check("reset_fin",      64'(painter_finished), 64'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);

`ifdef SPRITE_PAINTER_CLEAR_EN
        clear_slots();
        run_frame("clear", -1);
`else
        // Single 4x2 sprite, fully on screen.
        set_slot(18, 10, 0, 4, 2, 100, 50);
        run_frame("basic", -1);
        check("basic_first", 64'(got_at(0)), 64'(64100 * 4 + 1));
        check("basic_last",  64'(got_at(7)), 64'(65383 * 4 + 1));

        // frame_start repeated mid-DRAW is ignored.
        run_frame("repulse", 21);

        // One transparent texel.
        rom_mem[11] = 2'd0;
        run_frame("transp", -1);
        found = 0;
        foreach (got_q[i]) if (got_q[i] / 4 == 64101) found = 1;
        check("transp_64101_absent", 64'(found), 64'(0));
        rom_mem[11] = 2'd1;

        // Clipped at the top-left corner.
        clear_slots();
        set_slot(18, 10, 0, 4, 2, -2, -1);
        run_frame("clip_tl", -1);
        check("clip_tl_w0", 64'(got_at(0)), 64'(0 * 4 + 1));
        check("clip_tl_w1", 64'(got_at(1)), 64'(1 * 4 + 1));

        // Clipped at the bottom-right corner, no wrap.
        clear_slots();
        set_slot(18, 10, 0, 4, 2, 1278, 299);
        run_frame("clip_br", -1);
        check("clip_br_w0", 64'(got_at(0)), 64'(383998 * 4 + 1));
        check("clip_br_w1", 64'(got_at(1)), 64'(383999 * 4 + 1));

        // Overlap: the later slot wins.
        fill_rom(0);
        rom_mem[0] = 2'd1; rom_mem[1] = 2'd1;
        rom_mem[SHEET_W] = 2'd1; rom_mem[SHEET_W + 1] = 2'd1;
        rom_mem[100] = 2'd2; rom_mem[101] = 2'd2;
        rom_mem[SHEET_W + 100] = 2'd2; rom_mem[SHEET_W + 101] = 2'd2;
        clear_slots();
        set_slot(11, 0, 0, 2, 2, 5, 5);
        set_slot(18, 100, 0, 2, 2, 4, 4);
        run_frame("overlap", -1);
        last_d = -1;
        foreach (got_q[i]) if (got_q[i] / 4 == 6405) last_d = got_q[i] % 4;
        check("overlap_6405", 64'(last_d), 64'(2));

        // Reset mid-DRAW, then a clean frame afterwards.
        fill_rom(1);
        reset_mid_draw();
        run_frame("post_rst", -1);

        // Randomized tables over a random sheet.
        for (int a = 0; a < ROM_WORDS; a++) rom_mem[a] = 2'($urandom_range(0, 3));
        for (int it = 0; it < 4; it++) begin
            clear_slots();
            for (int s = 0; s < RENDER_SLOTS; s++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int w, h;
                    w = $urandom_range(1, 6);
                    h = $urandom_range(1, 5);
                    set_slot(s, $urandom_range(0, SHEET_W - w), $urandom_range(0, SHEET_H - h),
                             w, h, int'($urandom_range(0, SCREEN_W + 12)) - 8,
                             int'($urandom_range(0, SCREEN_H + 12)) - 8);
                end
            end
            run_frame($sformatf("rand%0d", it), -1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_painter.md
Name: sprite_painter

Overview:
- Downstream stage of the game-logic block. Consumes the per-slot sprite descriptors (sheet rectangle plus signed screen position) and blits them into the back framebuffer, one pixel per cycle.
- Reads the sprite-sheet ROM and writes the framebuffer.
- Raises painter_finished when the frame is complete; the game-logic block uses its rising edge to step the game loop.

Parameters:
- RENDER_SLOTS, 32, number of descriptor slots; slot 0 is painted first, so it ends up at the back.
- SCREEN_W, 1280, framebuffer width in pixels (2x GAME_WIDTH).
- SCREEN_H, 300, framebuffer height in pixels (2x GAME_HEIGHT).
- SHEET_W, 2404, sprite-sheet width in pixels.
- SHEET_H, 140, sprite-sheet height in pixels.
- PIXEL_W, 2, bits per pixel; value 0 means transparent.
- BG_COLOR, 2'd0, fill value used by the clear phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle pulse from the display side after a buffer swap; starts painting.
- sprite  in  sprite_t[RENDER_SLOTS]  sheet x/y/w/h per slot; w=0 or h=0 marks the slot empty.
- pos  in  pos_t[RENDER_SLOTS]  signed screen x/y of each slot's top-left corner.
- rom_addr  out  $clog2(SHEET_W*SHEET_H)  sprite-sheet read address.
- rom_data  in  PIXEL_W  pixel data, valid 1 cycle after rom_addr.
- fb_addr  out  $clog2(SCREEN_W*SCREEN_H)  framebuffer write address.
- fb_data  out  PIXEL_W  framebuffer write data.
- fb_we  out  1  framebuffer write strobe.
- busy  out  1  high from acceptance of frame_start until painter_finished rises.
- painter_finished  out  1  level; high from frame completion until the next accepted frame_start.

Behaviour:
- Reset values: all outputs 0, state IDLE, slot index 0, pipeline valid bits cleared.
- Reset mid-frame aborts the frame immediately. Writes still in the pipeline are dropped, and fb_we is 0 on the cycle after rst.
- States: IDLE -> (CLEAR) -> SCAN -> DRAW -> SCAN ... -> DRAIN -> DONE.
- IDLE/DONE:
  - frame_start=1 is accepted: busy<=1, painter_finished<=0, slot<=0.
  - Next state is CLEAR if compiled in, otherwise SCAN.
- frame_start while busy is ignored; no restart and no state change.
- SCAN, 1 cycle per slot:
  - Latch sprite[slot] and pos[slot]; clear the row and column counters.
  - Empty slot: slot++ and stay in SCAN.
  - Non-empty slot: go to DRAW.
  - After slot RENDER_SLOTS-1 has been handled, go to DRAIN.
- DRAW, 1 cycle per pixel, row-major:
  - rom_addr = (sy+r)*SHEET_W + (sx+c).
  - Screen coordinates: px = pos.x + c, py = pos.y + r (signed 13-bit arithmetic).
  - Pixel valid = 0<=px<SCREEN_W and 0<=py<SCREEN_H.
  - After c=w-1, r=h-1: slot++ and return to SCAN.
  - A non-empty slot therefore costs exactly 1 + w*h cycles.
- Pipeline, 2 stages:
  - Stage 1 registers the fb address and valid bit alongside the ROM read.
  - Stage 2: fb_we = valid and rom_data != 0; fb_addr = py*SCREEN_W + px; fb_data = rom_data.
  - A write appears 2 cycles after its address is issued.
  - Off-screen or transparent pixels consume their cycle but produce no write.
- DRAIN: 2 cycles to empty the pipeline, then DONE with painter_finished<=1 and busy<=0.
- Frame with all slots empty and no clear: painter_finished rises exactly 35 cycles after the cycle in which frame_start is sampled.
- Overlap: later slots overwrite earlier ones. No read-modify-write is performed.
- The caller holds sprite/pos stable while busy; the block samples them only in SCAN.

Optional Feature:
- Macro: SPRITE_PAINTER_CLEAR_EN.
- Defined: CLEAR state writes BG_COLOR to addresses 0 .. SCREEN_W*SCREEN_H-1, one per cycle with fb_we=1, before SCAN. This adds exactly SCREEN_W*SCREEN_H cycles.
- Undefined: no CLEAR state; the display side clears the back buffer.

Decomposition:
- New painter_pkg holds:
  - state_t enum;
  - SCREEN_W, SCREEN_H, SHEET_W, SHEET_H;
  - address-width localparams;
  - PIXEL_W and the TRANSPARENT value.
- sprite_t, pos_t and RENDER_SLOTS are imported from runner_pkg.
- One sub-module: blit_addr_gen. It holds the row/column counters and the ROM address, screen coordinates, clip flag and last-pixel flag for one latched descriptor.

Test Plan:
- Slot 18 = {x=10,y=0,w=4,h=2}, pos=(100,50), ROM region all 1s, CLEAR off -> 8 writes at fb_addr 64100..64103 and 65380..65383, data 1; painter_finished rises 35+8 cycles after frame_start.
- Same slot, with ROM pixel (c=1,r=0) set to 0 -> 7 writes; address 64101 is never written.
- pos=(-2,-1), w=4, h=2 -> only 2 writes, at fb_addr 0 and 1.
- pos=(1278,299), w=4, h=2 -> 2 writes at 383998 and 383999, no wrap-around.
- Slots 11 and 18 both cover pixel (5,5) with data 1 and 2 -> the last write to address 6405 has data 2.
- frame_start pulsed again mid-DRAW -> ignored, output identical to a single pulse.
- rst asserted mid-DRAW -> fb_we=0 the next cycle; all outputs back to reset values.
- CLEAR_EN defined, all slots empty -> 384000 writes of BG_COLOR at addresses 0..383999; painter_finished rises 384035 cycles after frame_start.
